text_video_ctrl: RTL and testbench



---
 rtl/text_video_ctrl.sv | 228 ++++++++++++++++++++++
 tb/tb_text_video_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/text_video_ctrl.sv
// text_video_ctrl: text-mode display controller.
//
// A CPU-visible character/attribute RAM holds one 16-bit cell per text position:
// {bg[3:0], fg[3:0], ascii[7:0]}. A two-stage registered pipeline turns the pixel
// coordinate from the timing generator into an 8-bit RRRGGGBB colour. Glyph rows
// come from an external combinational font ROM. Features: hardware row scroll,
// blinking underline cursor, display/cursor enables.
//
// Ports:
//   clk, reset          system clock, asynchronous active-high reset
//   x_ptr, y_ptr        current pixel coordinate
//   frame_start         one-cycle pulse per frame, drives the blink timer
//   color               RRRGGGBB pixel colour, two cycles after x_ptr/y_ptr
//   font_addr           {ascii, scanline} to the font ROM
//   font_data           glyph row from the font ROM, MSB = leftmost pixel
//   STB, WE, ADDR,
//   DAT_I, DAT_O, ACK   CPU bus (word addressed, single-cycle ACK pulse)
//
// Register map (word address, ADDR[31:13] ignored):
//   ADDR[12]=0  text RAM cell ADDR[11:0]
//   0x1000      SCROLL  row offset (writes stored modulo ROWS)
//   0x1001      CURSOR  cell index
//   0x1002      CTRL    bit0 display enable, bit1 cursor enable
//
// Optional build macro TEXT_ATTR_BLINK_EN: cell bit15 becomes a per-cell blink
// attribute (glyph hidden while the blink phase is 0) and bg is limited to 3 bits.
// Without it bit15 is the background intensity bit.

module text_video_ctrl #(
    parameter int unsigned COLS         = 80,
    parameter int unsigned ROWS         = 30,
    parameter int unsigned CHAR_W       = 8,
    parameter int unsigned CHAR_H       = 16,
    parameter int unsigned BLINK_FRAMES = 30
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [9:0]        x_ptr,
    input  logic [9:0]        y_ptr,
    input  logic              frame_start,
    output logic [7:0]        color,
    output logic [11:0]       font_addr,
    input  logic [CHAR_W-1:0] font_data,
    input  logic              STB,
    input  logic              WE,
    input  logic [31:0]       ADDR,
    input  logic [31:0]       DAT_I,
    output logic [31:0]       DAT_O,
    output logic              ACK
);

    localparam int unsigned CELLS = COLS * ROWS;
    localparam int unsigned XW    = (CHAR_W > 1) ? $clog2(CHAR_W) : 1;
    localparam int unsigned BW    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    // 4-bit IRGB to RRRGGGBB.
    function automatic logic [7:0] palette(input logic [3:0] irgb);
        logic [2:0] r3;
        logic [2:0] g3;
        logic [1:0] b2;
        r3 = irgb[2] ? (irgb[3] ? 3'b111 : 3'b100) : 3'b000;
        g3 = irgb[1] ? (irgb[3] ? 3'b111 : 3'b100) : 3'b000;
        b2 = irgb[0] ? (irgb[3] ? 2'b11 : 2'b10) : 2'b00;
        return {r3, g3, b2};
    endfunction

    logic [15:0] text_ram [CELLS];

    logic [4:0]    scroll_q;
    logic [11:0]   cursor_q;
    logic [1:0]    ctrl_q;
    logic [BW-1:0] blink_cnt_q;
    logic          blink_phase_q;
    logic          ack_q;
    logic [31:0]   dat_o_q;
    logic [7:0]    color_q;

    // Stage 0 pipeline registers
    logic [15:0]   cell_q;
    logic [XW-1:0] x_off_q;
    logic [3:0]    y_off_q;
    logic          in_area_q;
    logic          cur_hit_q;

    assign ACK   = ack_q;
    assign DAT_O = dat_o_q;
    assign color = color_q;

    // Upper address bits are don't-care.
    logic unused_addr_bits;
    assign unused_addr_bits = ^ADDR[31:13];

    // ---------------------------------------------------------------- bus decode
    logic        bus_go;
    logic        cell_ok;
    logic [31:0] bus_rdata;

    assign bus_go  = STB & ~ack_q;
    assign cell_ok = ~ADDR[12] && (ADDR[11:0] < 12'(CELLS));

    always_comb begin
        bus_rdata = '0;
        if (!ADDR[12]) begin
            if (cell_ok) begin
                bus_rdata = {16'b0, text_ram[ADDR[11:0]]};
            end
        end else begin
            case (ADDR[11:0])
                12'h000: bus_rdata = {27'b0, scroll_q};
                12'h001: bus_rdata = {20'b0, cursor_q};
                12'h002: bus_rdata = {30'b0, ctrl_q};
                default: bus_rdata = '0;
            endcase
        end
    end

    // Text RAM write port; no reset so it maps onto block RAM storage.
    always_ff @(posedge clk) begin
        if (bus_go && WE && cell_ok) begin
            text_ram[ADDR[11:0]] <= DAT_I[15:0];
        end
    end

    // ------------------------------------------------------------- stage 0 comb
    logic [9:0]  col;
    logic [9:0]  text_row;
    logic [10:0] row_sum;
    logic [10:0] row_wrap;
    logic        in_area;
    logic [11:0] disp_idx;
    logic [11:0] cur_idx;

    always_comb begin
        col      = x_ptr / 10'(CHAR_W);
        text_row = y_ptr / 10'(CHAR_H);
        row_sum  = {1'b0, text_row} + {6'b0, scroll_q};
        // Both terms are below ROWS inside the visible area, so one subtract suffices.
        row_wrap = (row_sum >= 11'(ROWS)) ? row_sum - 11'(ROWS) : row_sum;
        in_area  = ({1'b0, x_ptr} < 11'(COLS * CHAR_W)) &&
                   ({1'b0, y_ptr} < 11'(ROWS * CHAR_H));
        disp_idx = in_area ? (12'(row_wrap) * 12'(COLS) + 12'(col)) : 12'd0;
        // Cursor is positioned on screen, so it ignores the scroll offset.
        cur_idx  = 12'(text_row) * 12'(COLS) + 12'(col);
    end

    // ------------------------------------------------------------- stage 1 comb
    logic       glyph_bit;
    logic       pix;
    logic [3:0] fg;
    logic [3:0] bg;
    logic [7:0] color_d;

    assign font_addr = {cell_q[7:0], y_off_q};
    assign glyph_bit = font_data[XW'(CHAR_W - 1) - x_off_q];

    always_comb begin
        fg  = cell_q[11:8];
        pix = glyph_bit;
`ifdef TEXT_ATTR_BLINK_EN
        bg  = {1'b0, cell_q[14:12]};
        if (cell_q[15] && !blink_phase_q) begin
            pix = 1'b0;
        end
`else
        bg  = cell_q[15:12];
`endif
        // Cursor is a two-scanline underline shown during the on half of the blink.
        if (cur_hit_q && ctrl_q[1] && blink_phase_q && (y_off_q >= 4'(CHAR_H - 2))) begin
            pix = 1'b1;
        end
        if (!in_area_q || !ctrl_q[0]) begin
            color_d = 8'h00;
        end else begin
            color_d = palette(pix ? fg : bg);
        end
    end

    // ------------------------------------------------------------------- state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scroll_q      <= '0;
            cursor_q      <= '0;
            ctrl_q        <= 2'b01;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            ack_q         <= 1'b0;
            dat_o_q       <= '0;
            color_q       <= '0;
            cell_q        <= '0;
            x_off_q       <= '0;
            y_off_q       <= '0;
            in_area_q     <= 1'b0;
            cur_hit_q     <= 1'b0;
        end else begin
            ack_q <= bus_go;
            if (bus_go) begin
                dat_o_q <= bus_rdata;
                if (WE && ADDR[12]) begin
                    case (ADDR[11:0])
                        12'h000: scroll_q <= 5'(DAT_I % 32'(ROWS));
                        12'h001: cursor_q <= DAT_I[11:0];
                        12'h002: ctrl_q   <= DAT_I[1:0];
                        default: ;
                    endcase
                end
            end

            if (frame_start) begin
                if (blink_cnt_q == BW'(BLINK_FRAMES - 1)) begin
                    blink_cnt_q   <= '0;
                    blink_phase_q <= ~blink_phase_q;
                end else begin
                    blink_cnt_q <= blink_cnt_q + 1'b1;
                end
            end

            // Non-blocking read gives the pre-write value on a same-cycle bus write.
            cell_q    <= text_ram[disp_idx];
            x_off_q   <= XW'(x_ptr % 10'(CHAR_W));
            y_off_q   <= 4'(y_ptr % 10'(CHAR_H));
            in_area_q <= in_area;
            cur_hit_q <= in_area && (cur_idx == cursor_q);

            color_q <= color_d;
        end
    end

endmodule

// File: tb/tb_text_video_ctrl.sv
// Directed self-checking bench for text_video_ctrl (BLINK_FRAMES overridden to 2).
module tb_text_video_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  x_ptr;
    logic [9:0]  y_ptr;
    logic        frame_start;
    logic [7:0]  color;
    logic [11:0] font_addr;
    logic [7:0]  font_data;
    logic        STB;
    logic        WE;
    logic [31:0] ADDR;
    logic [31:0] DAT_I;
    logic [31:0] DAT_O;
    logic        ACK;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Font ROM model: only 'A' scanline 4 has pixels (0x18), everything else blank.
    always_comb font_data = (font_addr == 12'h414) ? 8'h18 : 8'h00;

    text_video_ctrl #(
        .BLINK_FRAMES (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .x_ptr       (x_ptr),
        .y_ptr       (y_ptr),
        .frame_start (frame_start),
        .color       (color),
        .font_addr   (font_addr),
        .font_data   (font_data),
        .STB         (STB),
        .WE          (WE),
        .ADDR        (ADDR),
        .DAT_I       (DAT_I),
        .DAT_O       (DAT_O),
        .ACK         (ACK)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic bus_xfer(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            output logic [31:0] rdata);
        logic seen;
        seen = 1'b0;
        @(negedge clk);
        STB   = 1'b1;
        WE    = we;
        ADDR  = addr;
        DAT_I = wdata;
        for (int i = 0; i < 4 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (ACK) seen = 1'b1;
        end
        rdata = DAT_O;
        if (!seen) check_eq("bus_ack_timeout", {31'b0, seen}, 32'd1);
        @(negedge clk);
        STB = 1'b0;
        WE  = 1'b0;
    endtask

    task automatic bus_wr(input logic [31:0] addr, input logic [31:0] data);
        logic [31:0] d;
        bus_xfer(1'b1, addr, data, d);
    endtask

    task automatic bus_rd_check(input string tag, input logic [31:0] addr,
                                input logic [31:0] exp);
        logic [31:0] d;
        bus_xfer(1'b0, addr, 32'h0, d);
        check_eq(tag, d, exp);
    endtask

    task automatic pix_check(input string tag, input logic [9:0] x, input logic [9:0] y,
                             input logic [7:0] exp);
        @(negedge clk);
        x_ptr = x;
        y_ptr = y;
        @(posedge clk);
        @(posedge clk);
        #1;
        check_eq(tag, {24'b0, color}, {24'b0, exp});
    endtask

    task automatic frame_pulse();
        @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        x_ptr       = 10'd640;
        y_ptr       = 10'd0;
        frame_start = 1'b0;
        STB         = 1'b0;
        WE          = 1'b0;
        ADDR        = '0;
        DAT_I       = '0;

        #1;
        check_eq("init_color", {24'b0, color}, 32'h0);
        check_eq("init_ack", {31'b0, ACK}, 32'h0);
        check_eq("init_dat_o", DAT_O, 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // 'A', fg bright white, bg blue
        bus_wr(32'h0000_0000, 32'h0000_1F41);
        bus_rd_check("rd_cell0", 32'h0, 32'h1F41);
        pix_check("pix_A_on", 10'd3, 10'd4, 8'hFF);
        pix_check("pix_A_bg", 10'd0, 10'd4, 8'h02);

        // Exact two-cycle latency: out-of-area, then (3,4), then (0,4)
        @(negedge clk);
        x_ptr = 10'd640;
        y_ptr = 10'd4;
        repeat (2) @(posedge clk);
        @(negedge clk);
        x_ptr = 10'd3;
        @(posedge clk);
        #1;
        check_eq("lat_cycle1", {24'b0, color}, 32'h00);
        @(negedge clk);
        x_ptr = 10'd0;
        @(posedge clk);
        #1;
        check_eq("lat_cycle2", {24'b0, color}, 32'hFF);
        @(posedge clk);
        #1;
        check_eq("lat_cycle3", {24'b0, color}, 32'h02);

        // STB held high: alternating ACK, out-of-range cell reads as 0
        bus_rd_check("rd_cell0_again", 32'h0, 32'h1F41);
        @(negedge clk);
        STB  = 1'b1;
        WE   = 1'b0;
        ADDR = 32'd2400;
        check_eq("hold_ack0", {31'b0, ACK}, 32'd0);
        @(negedge clk);
        check_eq("hold_ack1", {31'b0, ACK}, 32'd1);
        check_eq("rd_cell2400", DAT_O, 32'h0);
        @(negedge clk);
        check_eq("hold_ack2", {31'b0, ACK}, 32'd0);
        @(negedge clk);
        check_eq("hold_ack3", {31'b0, ACK}, 32'd1);
        STB = 1'b0;
        bus_rd_check("rd_cell0_third", 32'h0, 32'h1F41);
        bus_rd_check("rd_unmapped", 32'h0000_1003, 32'h0);
        bus_wr(32'h0000_1003, 32'hFFFF_FFFF);
        bus_rd_check("rd_ctrl_default", 32'h0000_1002, 32'h1);

        // Cursor on cell 5 (space glyph), blink with BLINK_FRAMES=2
        bus_wr(32'h0000_0005, 32'h0000_1F20);
        bus_wr(32'h0000_1001, 32'd5);
        bus_wr(32'h0000_1002, 32'd3);
        bus_rd_check("rd_cursor", 32'h0000_1001, 32'd5);
        pix_check("cur_phase0", 10'd40, 10'd15, 8'h02);
        frame_pulse();
        pix_check("cur_one_pulse", 10'd40, 10'd15, 8'h02);
        frame_pulse();
        pix_check("cur_phase1", 10'd40, 10'd15, 8'hFF);
        pix_check("cur_phase1_y14", 10'd40, 10'd14, 8'hFF);
        pix_check("cur_phase1_y13", 10'd40, 10'd13, 8'h02);
        frame_pulse();
        frame_pulse();
        pix_check("cur_phase0_again", 10'd40, 10'd15, 8'h02);

        // Scroll: screen row 0 shows text row 29
        bus_wr(32'h0000_0910, 32'h0000_0F41);
        bus_wr(32'h0000_1000, 32'd29);
        pix_check("scroll29_on", 10'd3, 10'd4, 8'hFF);
        pix_check("scroll29_bg", 10'd0, 10'd4, 8'h00);
        bus_wr(32'h0000_1000, 32'd31);
        bus_rd_check("scroll_mod", 32'h0000_1000, 32'd1);
        bus_wr(32'h0000_1000, 32'd0);

        // Area boundaries
        bus_wr(32'h0000_004F, 32'h0000_3000);
        pix_check("edge_x639", 10'd639, 10'd4, 8'h12);
        pix_check("out_x640", 10'd640, 10'd4, 8'h00);
        pix_check("out_y480", 10'd3, 10'd480, 8'h00);

        // Display disable
        bus_wr(32'h0000_1002, 32'd0);
        pix_check("ctrl_off", 10'd3, 10'd4, 8'h00);
        bus_wr(32'h0000_1002, 32'd1);
        pix_check("ctrl_on", 10'd3, 10'd4, 8'hFF);

        // Mid-frame asynchronous reset
        bus_wr(32'd560, 32'h0000_0F41);
        bus_wr(32'h0000_1000, 32'd7);
        bus_wr(32'h0000_1002, 32'd3);
        bus_rd_check("rd_ctrl3", 32'h0000_1002, 32'd3);
        pix_check("pre_reset", 10'd3, 10'd4, 8'hFF);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_eq("rst_color", {24'b0, color}, 32'h0);
        check_eq("rst_ack", {31'b0, ACK}, 32'h0);
        check_eq("rst_dat_o", DAT_O, 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        bus_rd_check("rst_scroll", 32'h0000_1000, 32'd0);
        bus_rd_check("rst_ctrl", 32'h0000_1002, 32'd1);
        bus_rd_check("rst_cursor", 32'h0000_1001, 32'd0);
        pix_check("ram_kept", 10'd3, 10'd4, 8'hFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
